// File: rtl/byte_en_regfile.sv
// byte_en_regfile: DEPTH x DATA_W register file with per-byte write enables, a write-first
// registered read port and per-entry dirty flags. Optional lane parity via BYTE_EN_REGFILE_PARITY_EN.
module byte_en_regfile #(
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 8,
  parameter int                ADDR_W   = 3,
  parameter logic [DATA_W-1:0] INIT_VAL = {DATA_W{1'b0}},
  localparam int               LANES    = (DATA_W - 1) / 8 + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [LANES-1:0]  en,
  input  logic [DATA_W-1:0] d,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] q,
  output logic              q_valid,
  output logic [DEPTH-1:0]  dirty,
  input  logic              clr_dirty,
  output logic              par_err
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0]  wr_sel;
  logic [DEPTH-1:0]  dirty_q, dirty_d;
  logic [DATA_W-1:0] bit_en;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] q_q, q_d;
  logic              q_valid_q;

  // Each data bit follows the enable of the lane it belongs to; the top lane may be partial.
  for (genvar gi = 0; gi < DATA_W; gi++) begin : g_bit_en
    assign bit_en[gi] = en[gi / 8];
  end

  // An all-zero enable is not a write at all, so it neither changes data nor marks dirty.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    assign wr_sel[gi]  = we && (|en) && (waddr == ADDR_W'(gi));
    assign mem_d[gi]   = wr_sel[gi] ? ((mem_q[gi] & ~bit_en) | (d & bit_en)) : mem_q[gi];
    assign dirty_d[gi] = wr_sel[gi] | (dirty_q[gi] & ~clr_dirty);
  end

  // Reading the post-write value gives write-first bypass; no match means out of range.
  always_comb begin
    rd_word = INIT_VAL;
    for (int i = 0; i < DEPTH; i++) begin
      if (raddr == ADDR_W'(i)) begin
        rd_word = mem_d[i];
      end
    end
  end

  assign q_d = re ? rd_word : q_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= INIT_VAL;
      end
      q_q       <= INIT_VAL;
      q_valid_q <= 1'b0;
      dirty_q   <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      q_q       <= q_d;
      q_valid_q <= re;
      dirty_q   <= dirty_d;
    end
  end

  assign q       = q_q;
  assign q_valid = q_valid_q;
  assign dirty   = dirty_q;

`ifdef BYTE_EN_REGFILE_PARITY_EN
  logic [DEPTH-1:0][LANES-1:0] par_q, par_d;
  logic [LANES-1:0]            init_par, d_par, rd_par_calc, rd_par_stored, byp_lane;
  logic [DATA_W-1:0]           rd_raw;
  logic                        rd_in_range;
  logic                        par_err_q;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    localparam int LO = 8 * gi;
    localparam int HI = (8 * gi + 7 < DATA_W) ? 8 * gi + 7 : DATA_W - 1;
    assign init_par[gi]    = ^INIT_VAL[HI:LO];
    assign d_par[gi]       = ^d[HI:LO];
    assign rd_par_calc[gi] = ^rd_raw[HI:LO];
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_par
    assign par_d[gi] = wr_sel[gi] ? ((par_q[gi] & ~en) | (d_par & en)) : par_q[gi];
  end

  // The check uses stored data, not the bypassed word; lanes being overwritten are excluded.
  always_comb begin
    rd_raw        = INIT_VAL;
    rd_par_stored = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (raddr == ADDR_W'(i)) begin
        rd_raw        = mem_q[i];
        rd_par_stored = par_q[i];
      end
    end
  end

  assign rd_in_range = {1'b0, raddr} < (ADDR_W + 1)'(DEPTH);
  assign byp_lane    = (we && waddr == raddr) ? en : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_q     <= {DEPTH{init_par}};
      par_err_q <= 1'b0;
    end else begin
      par_q     <= par_d;
      par_err_q <= re && rd_in_range && (|((rd_par_calc ^ rd_par_stored) & ~byp_lane));
    end
  end

  assign par_err = par_err_q;
`else
  assign par_err = 1'b0;
`endif

endmodule

// File: doc/byte_en_regfile.md
Name: byte_en_regfile

Overview:
Parametrised multi-entry register file with per-byte write enables. It is the successor to the single byte-enable register.
- Adds DEPTH addressable entries, a registered read port with write-first bypass, and per-entry dirty tracking.
- Used for control/status banks and scratch storage written by partial-width bus masters.

Parameters:
DATA_W, 32, entry width in bits; need not be a multiple of 8 (last lane is partial)
DEPTH, 8, number of entries; 1 <= DEPTH <= 2**ADDR_W
ADDR_W, 3, address width
INIT_VAL, {DATA_W{1'b0}}, reset value of every entry and of q

Ports:
clk  input  1  clock; all state changes on rising edge
rst  input  1  reset, asynchronous, active-high
we  input  1  write strobe
waddr  input  ADDR_W  write address
en  input  (DATA_W-1)/8+1  byte-lane enables; lane k covers bits [8k+7:8k] clipped to DATA_W-1
d  input  DATA_W  write data
re  input  1  read strobe
raddr  input  ADDR_W  read address
q  output  DATA_W  registered read data
q_valid  output  1  one-cycle pulse; q updated this cycle
dirty  output  DEPTH  per-entry written-since-clear flags
clr_dirty  input  1  clear all dirty flags
par_err  output  1  parity error pulse (see Optional Feature)

Behaviour:
- Reset (async assert, any time, including mid-operation):
  - all entries = INIT_VAL; q = INIT_VAL; q_valid = 0; dirty = 0; par_err = 0.
  - A write or read in flight is discarded.
  - First accepted operation is on the first rising edge after rst deasserts.
- Write:
  - On an edge with we=1 and waddr < DEPTH, every bit i of entry[waddr] with en[i/8]=1 takes d[i]. All other bits hold.
  - we=1 with en all-zero: no data change and no dirty change.
  - waddr >= DEPTH: write ignored, no dirty change.
- Read latency 1:
  - On an edge with re=1, q <= entry[raddr] and q_valid <= 1.
  - On other edges q_valid <= 0 and q holds its last value.
  - raddr >= DEPTH: q <= INIT_VAL, q_valid <= 1.
- Same-edge read/write, same address (write-first bypass):
  - q takes, per bit, d[i] where en[i/8]=1, else the old entry bit.
  - q equals the entry contents after the write.
  - Different addresses: independent.
- Dirty tracking:
  - dirty[a] sets on an edge writing entry a with any en bit = 1.
  - clr_dirty=1 clears all dirty bits on that edge.
  - Simultaneous clr_dirty and write: the written entry ends dirty=1; all others end 0.
- Partial top lane, e.g. DATA_W=20: lanes 0,1 are full; lane 2 covers bits [19:16]. Enable width = 3.
- No back-pressure; a write and a read can be accepted every cycle.

Optional Feature:
Macro BYTE_EN_REGFILE_PARITY_EN.
- Defined:
  - One even-parity bit is stored per byte lane per entry. It is updated only for enabled lanes on write; reset parity is computed from INIT_VAL.
  - On read, stored parity is checked against the stored data. par_err pulses with q_valid if any lane mismatches.
  - Bypassed lanes are never errors.
  - Out-of-range reads never flag.
  - The bench forces a parity bit via hierarchical reference to provoke an error.
- Undefined: no parity storage; par_err is tied to 0.

Test Plan:
- Reset, then read all 8 entries back-to-back -> q=0x00000000 each cycle after re; q_valid high 8 consecutive cycles; dirty=0x00.
- Write entry 3: d=0xAABBCCDD, en=4'b1111; then d=0x11223344, en=4'b0101; read 3 -> q=0xAA22CC44; dirty=0x08.
- Same edge: write entry 5 (entry=0x0, d=0xFFFFFFFF, en=4'b0010) plus read 5 -> next cycle q=0x0000FF00, q_valid=1.
- Edge with clr_dirty=1 and write to entry 1 (en=4'b0001) while dirty=0x0C -> dirty=0x02; we=1 with en=0 to entry 6 -> dirty unchanged.
- Assert rst mid-burst after writes to entries 0..7 -> q=0 and dirty=0 immediately; q_valid=0; subsequent reads return 0.
- DATA_W=20, DEPTH=5: write addr 6 -> ignored; read addr 7 -> q=0, q_valid=1; en=3'b100, d=0xF0000 -> only bits [19:16] change.
